// File: rtl/decode_execute_core_if.sv
// decode_execute_core_if: fetch/write-back inputs and decoded control/datapath outputs of the decode-execute core
interface decode_execute_core_if;
  logic [15:0] instruction;
  logic [15:0] pc4;
  logic [15:0] write_data;
  logic        reg_dst;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic [1:0]  alu_op;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic        jump;
  logic [15:0] read_data1;
  logic [15:0] read_data2;
  logic [15:0] ext_imm;
  logic [15:0] alu_result;
  logic        zero;
  logic [15:0] branch_target;
  logic [15:0] jump_target;
  logic        pc_src;
  modport master (
    output instruction, pc4, write_data,
    input  reg_dst, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write, jump,
    input  read_data1, read_data2, ext_imm, alu_result, zero, branch_target, jump_target, pc_src
  );
  modport slave (
    input  instruction, pc4, write_data,
    output reg_dst, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write, jump,
    output read_data1, read_data2, ext_imm, alu_result, zero, branch_target, jump_target, pc_src
  );
endinterface

// File: rtl/decode_execute_core.sv
// decode_execute_core: control decode, 8x16 register file and ALU/branch/jump execute of the 16-bit core
module decode_execute_core #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  decode_execute_core_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  logic [3:0]            opcode;
  logic [AW-1:0]         rs, rt, rd, wr_addr;
  logic [2:0]            funct;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] a, rt_val, b, ext_imm, result;
  assign opcode  = bus.instruction[15:12];
  assign rs      = bus.instruction[11:9];
  assign rt      = bus.instruction[8:6];
  assign rd      = bus.instruction[5:3];
  assign funct   = bus.instruction[2:0];
  assign ext_imm = {{(DATA_WIDTH-6){bus.instruction[5]}}, bus.instruction[5:0]};
  assign bus.reg_dst    = opcode == OP_R;
  assign bus.branch     = opcode == OP_BEQ;
  assign bus.mem_read   = opcode == OP_LW;
  assign bus.mem_to_reg = opcode == OP_LW;
  assign bus.mem_write  = opcode == OP_SW;
  assign bus.alu_src    = opcode inside {OP_ADDI, OP_LW, OP_SW};
  assign bus.reg_write  = opcode inside {OP_R, OP_ADDI, OP_LW};
  assign bus.jump       = opcode == OP_J;
  assign bus.alu_op     = opcode == OP_R ? 2'b10 : opcode == OP_BEQ ? 2'b01 : 2'b00;
  // r0 is hardwired to zero on the read side; the write side never targets it either
  assign a       = rs == '0 ? '0 : regs_q[rs];
  assign rt_val  = rt == '0 ? '0 : regs_q[rt];
  assign b       = bus.alu_src ? ext_imm : rt_val;
  assign wr_addr = bus.reg_dst ? rd : rt;
  always_comb begin
    result = a + b;
    if (bus.alu_op == 2'b01) result = a - b;
    else if (bus.alu_op == 2'b10)
      case (funct)
        3'd1:    result = a - b;
        3'd2:    result = a & b;
        3'd3:    result = a | b;
        3'd4:    result = a ^ b;
        3'd5:    result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        3'd6:    result = a << b[3:0];
        3'd7:    result = a >> b[3:0];
        default: result = a + b;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (bus.reg_write && wr_addr != '0) regs_q[wr_addr] <= bus.write_data;
  end
  assign bus.read_data1    = a;
  assign bus.read_data2    = rt_val;
  assign bus.ext_imm       = ext_imm;
  assign bus.alu_result    = result;
  assign bus.zero          = result == '0;
  assign bus.pc_src        = bus.branch && bus.zero;
  assign bus.branch_target = bus.pc4 + {ext_imm[DATA_WIDTH-2:0], 1'b0};
  assign bus.jump_target   = {bus.pc4[15:13], bus.instruction[11:0], 1'b0};
endmodule

// File: tb/tb_decode_execute_core.sv
// tb_decode_execute_core: directed and randomized checks of decode_execute_core against an arithmetic reference model
module tb_decode_execute_core;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model_regs [8];
  logic [9:0] commit_ctl;
  logic [2:0] commit_dst;
  decode_execute_core_if bus();
  decode_execute_core dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;

  // control table: {reg_dst, branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write, jump}
  function automatic logic [9:0] exp_ctl(input logic [3:0] op);
    case (op)
      4'h0:    return 10'b1_0_0_0_10_0_0_1_0;
      4'h1:    return 10'b0_0_0_0_00_0_1_1_0;
      4'h2:    return 10'b0_0_1_1_00_0_1_1_0;
      4'h3:    return 10'b0_0_0_0_00_1_1_0_0;
      4'h4:    return 10'b0_1_0_0_01_0_0_0_0;
      4'h5:    return 10'b0_0_0_0_00_0_0_0_1;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [15:0] rd_model(input logic [2:0] idx);
    return idx == 3'd0 ? 16'h0 : model_regs[idx];
  endfunction

  function automatic int simm(input logic [5:0] v);
    return v[5] ? int'(v) - 64 : int'(v);
  endfunction

  function automatic logic [15:0] exp_alu(input logic [15:0] ins);
    logic [15:0] a, b;
    longint ia, ib, sa, sb;
    logic [3:0] op;
    op = ins[15:12];
    a = rd_model(ins[11:9]);
    b = (op inside {4'h1, 4'h2, 4'h3}) ? 16'(simm(ins[5:0])) : rd_model(ins[8:6]);
    ia = longint'(a);
    ib = longint'(b);
    sa = a[15] ? ia - 65536 : ia;
    sb = b[15] ? ib - 65536 : ib;
    if (op == 4'h4) return 16'(ia - ib);
    if (op != 4'h0) return 16'(ia + ib);
    case (ins[2:0])
      3'd0:    return 16'(ia + ib);
      3'd1:    return 16'(ia - ib);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 16'd1 : 16'd0;
      3'd6:    return 16'(ia * (longint'(1) << b[3:0]));
      default: return 16'(ia / (longint'(1) << b[3:0]));
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) model_regs[i] <= 16'h0;
    end else begin
      commit_ctl = exp_ctl(bus.instruction[15:12]);
      commit_dst = commit_ctl[9] ? bus.instruction[5:3] : bus.instruction[8:6];
      if (commit_ctl[1] && commit_dst != 3'd0) model_regs[commit_dst] <= bus.write_data;
    end
  end

  task automatic apply(input logic [15:0] ins, input logic [15:0] pc, input logic [15:0] wd);
    @(negedge clock);
    bus.instruction = ins;
    bus.pc4 = pc;
    bus.write_data = wd;
    #1;
  endtask

  task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
    apply({4'h1, 3'd0, r, 6'd0}, 16'h0, v);
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    #1;
    vectors++; if (bus.read_data1 !== 16'h0) begin miscompares++; $display("FAIL reset_rd1 got %h exp 0000", bus.read_data1); end
    vectors++; if (bus.read_data2 !== 16'h0) begin miscompares++; $display("FAIL reset_rd2 got %h exp 0000", bus.read_data2); end
    vectors++; if (bus.alu_result !== 16'h0) begin miscompares++; $display("FAIL reset_alu got %h exp 0000", bus.alu_result); end
    vectors++; if (bus.zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got %b exp 1", bus.zero); end
    vectors++; if (bus.reg_dst !== 1'b1 || bus.reg_write !== 1'b1) begin miscompares++; $display("FAIL reset_rtype_ctl got dst=%b wr=%b exp 1 1", bus.reg_dst, bus.reg_write); end
    bus.instruction = 16'h1040;
    bus.write_data = 16'h7777;
    @(posedge clock);
    @(negedge clock);
    bus.instruction = 16'hF000;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply({4'hF, 3'(i), 3'(i), 6'd0}, 16'h0, 16'h0);
      vectors++; if (bus.read_data1 !== 16'h0 || bus.read_data2 !== 16'h0) begin miscompares++; $display("FAIL reset_regs r%0d got %h/%h exp 0000", i, bus.read_data1, bus.read_data2); end
    end
  endtask

  task automatic test_addi_writeback;
    apply(16'h1045, 16'h0, 16'h0005);
    vectors++; if (bus.ext_imm !== 16'h0005) begin miscompares++; $display("FAIL addi_ext got %h exp 0005", bus.ext_imm); end
    vectors++; if (bus.alu_result !== 16'h0005) begin miscompares++; $display("FAIL addi_alu got %h exp 0005", bus.alu_result); end
    vectors++; if (bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0) begin miscompares++; $display("FAIL addi_ctl got wr=%b dst=%b exp 1 0", bus.reg_write, bus.reg_dst); end
    apply(16'h1240, 16'h0, 16'h1234);
    vectors++; if (bus.read_data1 !== 16'h0005) begin miscompares++; $display("FAIL writeback_r1 got %h exp 0005", bus.read_data1); end
    vectors++; if (bus.alu_result !== 16'h0005) begin miscompares++; $display("FAIL no_bypass_alu got %h exp 0005", bus.alu_result); end
    apply(16'hF200, 16'h0, 16'h0);
    vectors++; if (bus.read_data1 !== 16'h1234) begin miscompares++; $display("FAIL overwrite_r1 got %h exp 1234", bus.read_data1); end
  endtask

  task automatic test_neg_imm;
    apply({4'h4, 3'd1, 3'd2, 6'h3E}, 16'h0010, 16'h0);
    vectors++; if (bus.ext_imm !== 16'hFFFE) begin miscompares++; $display("FAIL neg_ext got %h exp fffe", bus.ext_imm); end
    vectors++; if (bus.branch_target !== 16'h000C) begin miscompares++; $display("FAIL neg_btarget got %h exp 000c", bus.branch_target); end
    apply({4'h3, 3'd1, 3'd2, 6'h1F}, 16'h0010, 16'h0);
    vectors++; if (bus.ext_imm !== 16'h001F) begin miscompares++; $display("FAIL pos_ext got %h exp 001f", bus.ext_imm); end
    vectors++; if (bus.branch_target !== 16'h004E) begin miscompares++; $display("FAIL pos_btarget got %h exp 004e", bus.branch_target); end
  endtask

  task automatic test_funct_sweep;
    logic [15:0] exp_r [8];
    exp_r = '{16'd8, 16'd2, 16'd1, 16'd7, 16'd6, 16'd0, 16'h0028, 16'd0};
    set_reg(3'd1, 16'd5);
    set_reg(3'd2, 16'd3);
    for (int f = 0; f < 8; f++) begin
      apply({4'h0, 3'd1, 3'd2, 3'd3, 3'(f)}, 16'h0, 16'h0);
      vectors++; if (bus.alu_result !== exp_r[f]) begin miscompares++; $display("FAIL funct%0d got %h exp %h", f, bus.alu_result, exp_r[f]); end
    end
    apply({4'h0, 3'd2, 3'd1, 3'd3, 3'd5}, 16'h0, 16'h0);
    vectors++; if (bus.alu_result !== 16'd1) begin miscompares++; $display("FAIL slt_swapped got %h exp 0001", bus.alu_result); end
  endtask

  task automatic test_beq;
    set_reg(3'd2, 16'd5);
    apply({4'h4, 3'd1, 3'd2, 6'd4}, 16'h0100, 16'h0);
    vectors++; if (bus.zero !== 1'b1 || bus.pc_src !== 1'b1) begin miscompares++; $display("FAIL beq_taken got z=%b src=%b exp 1 1", bus.zero, bus.pc_src); end
    set_reg(3'd2, 16'd3);
    apply({4'h4, 3'd1, 3'd2, 6'd4}, 16'h0100, 16'h0);
    vectors++; if (bus.zero !== 1'b0 || bus.pc_src !== 1'b0) begin miscompares++; $display("FAIL beq_not_taken got z=%b src=%b exp 0 0", bus.zero, bus.pc_src); end
    apply({4'h0, 3'd1, 3'd1, 3'd0, 3'd1}, 16'h0, 16'h0);
    vectors++; if (bus.zero !== 1'b1 || bus.pc_src !== 1'b0) begin miscompares++; $display("FAIL sub_zero_nobranch got z=%b src=%b exp 1 0", bus.zero, bus.pc_src); end
  endtask

  task automatic test_jump_reserved;
    apply(16'h5123, 16'hA000, 16'h0);
    vectors++; if (bus.jump !== 1'b1) begin miscompares++; $display("FAIL jump_flag got %b exp 1", bus.jump); end
    vectors++; if (bus.jump_target !== 16'hA246) begin miscompares++; $display("FAIL jump_target got %h exp a246", bus.jump_target); end
    for (int op = 6; op < 16; op++) begin
      apply({4'(op), 12'hFFF}, 16'h0, 16'hBEEF);
      vectors++; if ({bus.reg_dst, bus.branch, bus.mem_read, bus.mem_to_reg, bus.alu_op, bus.mem_write, bus.alu_src, bus.reg_write, bus.jump} !== 10'b0) begin miscompares++; $display("FAIL nop_ctl op=%h got nonzero control", op); end
    end
    apply(16'h0000, 16'h0, 16'hFFFF);
    apply(16'h1000, 16'h0, 16'hFFFF);
    apply(16'hF000, 16'h0, 16'h0);
    vectors++; if (bus.read_data1 !== 16'h0 || bus.read_data2 !== 16'h0) begin miscompares++; $display("FAIL r0_write got %h/%h exp 0000", bus.read_data1, bus.read_data2); end
  endtask

  task automatic test_async_reset;
    set_reg(3'd1, 16'h00AA);
    @(negedge clock);
    bus.instruction = {4'h1, 3'd1, 3'd2, 6'd1};
    bus.write_data = 16'hBEEF;
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (bus.read_data1 !== 16'h0) begin miscompares++; $display("FAIL async_clear got %h exp 0000", bus.read_data1); end
    @(posedge clock);
    @(negedge clock);
    bus.instruction = 16'hF000;
    reset_n = 1'b1;
    apply({4'hF, 3'd2, 3'd1, 6'd0}, 16'h0, 16'h0);
    vectors++; if (bus.read_data1 !== 16'h0 || bus.read_data2 !== 16'h0) begin miscompares++; $display("FAIL reset_blocks_write got %h/%h exp 0000", bus.read_data1, bus.read_data2); end
  endtask

  task automatic test_random;
    logic [15:0] ins, pc, wd, e_a, e_b, e_alu, e_bt, e_jt;
    logic [9:0] e_ctl, got_ctl;
    for (int n = 0; n < 300; n++) begin
      ins = 16'($urandom);
      pc = 16'($urandom);
      wd = 16'($urandom);
      apply(ins, pc, wd);
      e_ctl = exp_ctl(ins[15:12]);
      e_a = rd_model(ins[11:9]);
      e_b = rd_model(ins[8:6]);
      e_alu = exp_alu(ins);
      e_bt = 16'(int'(pc) + 2 * simm(ins[5:0]));
      e_jt = 16'((pc & 16'hE000) | ((ins & 16'h0FFF) << 1));
      got_ctl = {bus.reg_dst, bus.branch, bus.mem_read, bus.mem_to_reg, bus.alu_op, bus.mem_write, bus.alu_src, bus.reg_write, bus.jump};
      vectors++; if (got_ctl !== e_ctl) begin miscompares++; $display("FAIL rnd_ctl ins=%h got %b exp %b", ins, got_ctl, e_ctl); end
      vectors++; if (bus.read_data1 !== e_a || bus.read_data2 !== e_b) begin miscompares++; $display("FAIL rnd_read ins=%h got %h/%h exp %h/%h", ins, bus.read_data1, bus.read_data2, e_a, e_b); end
      vectors++; if (bus.ext_imm !== 16'(simm(ins[5:0]))) begin miscompares++; $display("FAIL rnd_ext ins=%h got %h", ins, bus.ext_imm); end
      vectors++; if (bus.alu_result !== e_alu || bus.zero !== (e_alu == 16'h0)) begin miscompares++; $display("FAIL rnd_alu ins=%h got %h z=%b exp %h", ins, bus.alu_result, bus.zero, e_alu); end
      vectors++; if (bus.branch_target !== e_bt || bus.jump_target !== e_jt) begin miscompares++; $display("FAIL rnd_targets ins=%h got %h/%h exp %h/%h", ins, bus.branch_target, bus.jump_target, e_bt, e_jt); end
      vectors++; if (bus.pc_src !== (e_ctl[8] && e_alu == 16'h0)) begin miscompares++; $display("FAIL rnd_pc_src ins=%h got %b", ins, bus.pc_src); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.instruction = 16'h0;
    bus.pc4 = 16'h0;
    bus.write_data = 16'h0;
    test_reset();
    test_addi_writeback();
    test_neg_imm();
    test_funct_sweep();
    test_beq();
    test_jump_reserved();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decode_execute_core.md
Name: decode_execute_core

Overview:
- Combined control-decode, register-file and execute stage of the 16-bit single-cycle processor.
- Decodes a 16-bit instruction into datapath control signals and reads or writes an 8x16 register file.
- Computes the ALU result, zero flag, branch target and jump target.
- Sits between instruction fetch (supplies instruction and PC+2) and memory/write-back (returns write data).

Parameters:
- DATA_WIDTH, 16, datapath and register width; only 16 is supported.
- NUM_REGS, 8, register count; register index is 3 bits.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- instruction  in  16  current instruction
- pc4  in  16  address of next sequential instruction
- write_data  in  16  register write-back data from WB
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- branch  out  1  conditional branch instruction
- mem_read  out  1  data memory read
- mem_to_reg  out  1  write back memory data
- alu_op  out  2  ALU operation class
- mem_write  out  1  data memory write
- alu_src  out  1  ALU operand B select: 1 = ext_imm, 0 = read_data2
- reg_write  out  1  register write enable
- jump  out  1  unconditional jump
- read_data1  out  16  register[rs]
- read_data2  out  16  register[rt]
- ext_imm  out  16  sign-extended instruction[5:0]
- alu_result  out  16  ALU output
- zero  out  1  alu_result == 0
- branch_target  out  16  pc4 + (ext_imm << 1)
- jump_target  out  16  {pc4[15:13], instruction[11:0], 1'b0}
- pc_src  out  1  branch & zero

Behaviour:
- Instruction fields:
  - opcode = [15:12], rs = [11:9], rt = [8:6], rd = [5:3], funct = [2:0], imm6 = [5:0].
  - ext_imm = {{10{imm6[5]}}, imm6}.
- Control decode is purely combinational on opcode. Signals not listed for an opcode are 0.
  - 0000 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 0001 addi: alu_src=1, reg_write=1, alu_op=00.
  - 0010 lw: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00.
  - 0011 sw: alu_src=1, mem_write=1, alu_op=00.
  - 0100 beq: branch=1, alu_op=01.
  - 0101 j: jump=1.
  - 0110-1111: all control outputs 0 (nop).
- ALU operands:
  - A = read_data1.
  - B = alu_src ? ext_imm : read_data2.
- ALU operation by alu_op:
  - alu_op 00: add.
  - alu_op 01: subtract (A-B).
  - alu_op 11: add (reserved).
  - alu_op 10, select by funct:
    - 000 add; 001 sub; 010 and; 011 or; 100 xor.
    - 101 slt: signed A<B gives 1, else 0.
    - 110 sll: A << B[3:0].
    - 111 srl: A >> B[3:0], logical.
- All arithmetic is modulo 2^16; overflow is ignored and not flagged.
- zero, branch_target, jump_target and pc_src are combinational.
  - pc_src is 1 only when branch=1 and zero=1.
- Register file:
  - 8 entries x 16 bits; reads are combinational.
  - Register 0 always reads 0; writes to it are discarded.
  - Write occurs on the rising edge of clock when reg_write=1.
  - Write address = reg_dst ? rd : rt; write data = write_data.
  - No internal bypass: a read of the register being written returns the old value until after the edge.
- Reset:
  - reset_n=0 asynchronously clears all registers to 0, independent of clock.
  - Writes are blocked while reset_n=0.
  - After release, read_data1 = read_data2 = 0 for every index until written.
  - Reset asserted mid-operation discards any pending write at that edge.
- No state other than the register file. The only latency is one clock edge for a register write to become visible.
- Undefined opcodes never write registers or memory.

Test Plan:
- Reset then R-type:
  - Assert reset_n=0.
  - Apply instruction 0x0000 (add r0,r0→r0) -> read_data1=read_data2=0, alu_result=0, zero=1, reg_dst=1, reg_write=1.
- addi and write-back:
  - Apply instruction 0x1045 (addi rt=r1, rs=r0, imm=5) -> ext_imm=0x0005, alu_result=5, reg_write=1, reg_dst=0.
  - Drive write_data=5 and clock one edge -> register r1 reads 5.
- Negative immediate:
  - imm6=0x3E gives ext_imm=0xFFFE.
  - With pc4=0x0010 -> branch_target=0x000C.
- R-type funct sweep with r1=5, r2=3 -> results:
  - add=8, sub=2, and=1, or=7, xor=6.
  - slt=0, and slt with operands swapped=1.
  - sll=0x0028, srl=0.
- beq taken and not taken:
  - r1=r2 with opcode 0100 -> zero=1, pc_src=1.
  - r1≠r2 -> pc_src=0.
- Jump and reserved opcode:
  - Opcode 0101 with instruction[11:0]=0x123 and pc4=0xA000 -> jump=1, jump_target=0xA246.
  - Opcode 1111 -> all control outputs 0.
  - Writing r0 with write_data=0xFFFF -> r0 still reads 0.
